// File: rtl/fma16_vector_recorder.sv
// Records fma16 operand/result traffic as 76-bit vector words {x,y,z,ctrl,result,flags}
// and replays them in capture order on a valid/ready dump stream.
module fma16_vector_recorder #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dump,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   x,
    input  logic [15:0]   y,
    input  logic [15:0]   z,
    input  logic [1:0]    roundmode,
    input  logic          mul,
    input  logic          add,
    input  logic          negp,
    input  logic          negz,
    input  logic [15:0]   result,
    input  logic [3:0]    flags,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [75:0]   out_data,
    output logic          out_last,
    output logic [AW:0]   count,
    output logic          full,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0] CNT_MAX = (AW + 1)'(DEPTH);

    state_t        state_q;
    logic [AW:0]   count_q;
    logic [AW:0]   rptr_q;
    logic [75:0]   mem [DEPTH];
    logic [75:0]   rd_data_q;
    logic          rd_valid_q;
    logic          rd_last_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [75:0]   out_data_q;

    logic          full_w;
    logic          in_ready_w;
    logic          wr_en;
    logic [75:0]   word_w;
    logic          out_fire;
    logic          out_load;
    logic          rd_issue;

    assign full_w     = (count_q == CNT_MAX);
    assign in_ready_w = (state_q == REC) && !full_w;
    assign wr_en      = in_valid && in_ready_w;
    assign word_w     = {x, y, z, 2'b00, roundmode, mul, add, negp, negz, result, flags};

    // Two-stage prefetch (RAM read register + output register) keeps one word per
    // cycle flowing and lets the output hold steady under backpressure.
    assign out_fire = out_valid_q && out_ready;
    assign out_load = rd_valid_q && (!out_valid_q || out_ready);
    assign rd_issue = (state_q == DUMP) && (rptr_q < count_q) && !(rd_valid_q && !out_load);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[AW-1:0]] <= word_w;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rptr_q[AW-1:0]];
            rd_last_q <= (rptr_q == (count_q - CNT_ONE));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= REC;
                        count_q <= '0;
                    end else if (dump && (count_q != '0)) begin
                        state_q    <= DUMP;
                        rptr_q     <= '0;
                        rd_valid_q <= 1'b0;
                    end
                end
                REC: begin
                    if (wr_en) begin
                        count_q <= count_q + CNT_ONE;
                    end
                    // An empty recording has nothing to stream, so fall back to IDLE.
                    if (dump) begin
                        rptr_q     <= '0;
                        rd_valid_q <= 1'b0;
                        state_q    <= (wr_en || (count_q != '0)) ? DUMP : IDLE;
                    end
                end
                DUMP: begin
                    if (rd_issue) begin
                        rd_valid_q <= 1'b1;
                        rptr_q     <= rptr_q + CNT_ONE;
                    end else if (out_load) begin
                        rd_valid_q <= 1'b0;
                    end
                    if (out_load) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_data_q;
                        out_last_q  <= rd_last_q;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (out_fire && out_last_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_w;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign count     = count_q;
    assign full      = full_w;
    assign state     = state_q;

endmodule

// File: tb/tb_fma16_vector_recorder.sv
// Directed bench for fma16_vector_recorder: a default-depth instance and a DEPTH=4
// instance share stimulus; hand-packed vector words are the expected values.
module tb_fma16_vector_recorder;

    logic        clk = 1'b0;
    logic        reset, start, dump, in_valid, out_ready;
    logic [15:0] x, y, z, result;
    logic [1:0]  roundmode;
    logic        mul, add, negp, negz;
    logic [3:0]  flags;

    logic        rdy_a, ov_a, ol_a, full_a;
    logic [75:0] od_a;
    logic [10:0] cnt_a;
    logic [1:0]  st_a;
    logic        rdy_b, ov_b, ol_b, full_b;
    logic [75:0] od_b;
    logic [2:0]  cnt_b;
    logic [1:0]  st_b;

    logic        sel;
    logic        ov, ol;
    logic [75:0] od;
    logic [1:0]  st;

    int n_cmp = 0;
    int n_err = 0;

    logic [75:0] got[$];
    logic        gotl[$];
    logic [75:0] expw [8];
    int          first_lat, last_cyc;
    logic        dump_done;

    localparam logic [75:0] V0 = 76'h3C00_4000_0000_18_4000_0;
    localparam logic [75:0] V1 = 76'h1111_2222_3333_26_4444_5;
    localparam logic [75:0] V2 = 76'hAAAA_BBBB_CCCC_3D_DDDD_F;
    localparam logic [75:0] V3 = 76'h0001_8000_7C00_01_FFFF_A;

    fma16_vector_recorder dut (
        .clk(clk), .reset(reset), .start(start), .dump(dump),
        .in_valid(in_valid), .in_ready(rdy_a),
        .x(x), .y(y), .z(z), .roundmode(roundmode),
        .mul(mul), .add(add), .negp(negp), .negz(negz),
        .result(result), .flags(flags),
        .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_last(ol_a),
        .count(cnt_a), .full(full_a), .state(st_a)
    );

    fma16_vector_recorder #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .dump(dump),
        .in_valid(in_valid), .in_ready(rdy_b),
        .x(x), .y(y), .z(z), .roundmode(roundmode),
        .mul(mul), .add(add), .negp(negp), .negz(negz),
        .result(result), .flags(flags),
        .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_last(ol_b),
        .count(cnt_b), .full(full_b), .state(st_b)
    );

    assign ov = sel ? ov_b : ov_a;
    assign ol = sel ? ol_b : ol_a;
    assign od = sel ? od_b : od_a;
    assign st = sel ? st_b : st_a;

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cap(input logic [75:0] w);
        x = w[75:60]; y = w[59:44]; z = w[43:28];
        roundmode = w[25:24]; mul = w[23]; add = w[22]; negp = w[21]; negz = w[20];
        result = w[19:4]; flags = w[3:0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_dump(input int plen, input logic [7:0] pat);
        int          cyc;
        int          vi;
        logic        held;
        logic [75:0] hd;
        got.delete();
        gotl.delete();
        out_ready = 1'b1;
        dump = 1'b1;
        step();
        dump = 1'b0;
        in_valid = 1'b0;
        cyc = 0; vi = 0; held = 1'b0; hd = '0;
        first_lat = -1; last_cyc = -1; dump_done = 1'b0;
        while (cyc < 40 && !dump_done) begin
            step();
            cyc++;
            if (held) begin
                chk("stall_valid", 76'(ov), 76'(1));
                chk("stall_data", od, hd);
            end
            if (ov && first_lat < 0) first_lat = cyc;
            if (ov) begin
                out_ready = (vi < plen) ? pat[vi] : 1'b1;
                vi++;
            end else begin
                out_ready = 1'b1;
            end
            held = ov && !out_ready;
            hd = od;
            if (ov && out_ready) begin
                got.push_back(od);
                gotl.push_back(ol);
                if (ol) begin
                    dump_done = 1'b1;
                    last_cyc = cyc;
                end
            end
        end
        chk("dump_done", 76'(dump_done), 76'(1));
        step();
        out_ready = 1'b1;
        chk("dump_end_state", 76'(st), 76'(0));
        chk("dump_end_valid", 76'(ov), 76'(0));
    endtask

    task automatic check_words(input string tag, input int n);
        chk({tag, "_n"}, 76'(got.size()), 76'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), got[i], expw[i]);
            chk($sformatf("%s_l%0d", tag, i), 76'(gotl[i]), 76'(i == n - 1));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        sel = 1'b0;
        reset = 1'b0; start = 1'b0; dump = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; z = '0; roundmode = '0; mul = 0; add = 0; negp = 0; negz = 0;
        result = '0; flags = '0;
        step();
        step();
        reset = 1'b1;

        chk("rst_state", 76'(st_a), 76'(0));
        chk("rst_count", 76'(cnt_a), 76'(0));
        chk("rst_valid", 76'(ov_a), 76'(0));
        chk("rst_last", 76'(ol_a), 76'(0));
        chk("rst_data", od_a, 76'(0));
        chk("rst_inready", 76'(rdy_a), 76'(0));

        // dump with an empty buffer is ignored
        dump = 1'b1;
        step();
        dump = 1'b0;
        chk("empty_dump_state", 76'(st_a), 76'(0));
        step();
        chk("empty_dump_valid", 76'(ov_a), 76'(0));

        // single capture
        pulse_start();
        chk("rec_state", 76'(st_a), 76'(1));
        chk("rec_inready", 76'(rdy_a), 76'(1));
        cap(V0);
        chk("t1_count", 76'(cnt_a), 76'(1));
        expw[0] = V0;
        do_dump(0, 8'h00);
        check_words("t1", 1);
        chk("t1_lat", 76'(first_lat), 76'(2));
        chk("t1_count_after", 76'(cnt_a), 76'(1));

        // three back-to-back captures, full-rate dump
        pulse_start();
        cap(V1); cap(V2); cap(V3);
        chk("t2_count", 76'(cnt_a), 76'(3));
        expw[0] = V1; expw[1] = V2; expw[2] = V3;
        do_dump(0, 8'h00);
        check_words("t2", 3);
        chk("t2_lat", 76'(first_lat), 76'(2));
        chk("t2_burst", 76'(last_cyc), 76'(4));

        // overflow on the DEPTH=4 instance
        pulse_start();
        cap(V0); cap(V1); cap(V2); cap(V3);
        chk("t3_full", 76'(full_b), 76'(1));
        chk("t3_inready", 76'(rdy_b), 76'(0));
        chk("t3_count4", 76'(cnt_b), 76'(4));
        cap(V1); cap(V2);
        chk("t3_count4_sat", 76'(cnt_b), 76'(4));
        chk("t3_count_big", 76'(cnt_a), 76'(6));
        sel = 1'b1;
        expw[0] = V0; expw[1] = V1; expw[2] = V2; expw[3] = V3;
        do_dump(0, 8'h00);
        check_words("t3", 4);
        sel = 1'b0;
        for (int i = 0; i < 10 && st_a != 2'd0; i++) step();
        chk("t3_big_idle", 76'(st_a), 76'(0));

        // backpressure 1,0,0,1,1 then a replay
        pulse_start();
        cap(V1); cap(V2); cap(V3);
        expw[0] = V1; expw[1] = V2; expw[2] = V3;
        do_dump(5, 8'b0001_1001);
        check_words("t4", 3);
        chk("t4_count", 76'(cnt_a), 76'(3));
        do_dump(0, 8'h00);
        check_words("t4_replay", 3);

        // capture accepted in the same cycle as dump
        pulse_start();
        cap(V2); cap(V3);
        x = V1[75:60]; y = V1[59:44]; z = V1[43:28];
        roundmode = V1[25:24]; mul = V1[23]; add = V1[22]; negp = V1[21]; negz = V1[20];
        result = V1[19:4]; flags = V1[3:0];
        in_valid = 1'b1;
        expw[0] = V2; expw[1] = V3; expw[2] = V1;
        do_dump(0, 8'h00);
        check_words("t5", 3);
        chk("t5_count", 76'(cnt_a), 76'(3));

        // reset during the second word of a dump
        dump = 1'b1;
        step();
        dump = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("t6_w0", od_a, V2);
        step();
        chk("t6_w1", od_a, V3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_state", 76'(st_a), 76'(0));
        chk("t6_valid", 76'(ov_a), 76'(0));
        chk("t6_count", 76'(cnt_a), 76'(0));
        dump = 1'b1;
        step();
        dump = 1'b0;
        chk("t6_dump_state", 76'(st_a), 76'(0));
        step();
        step();
        chk("t6_dump_valid", 76'(ov_a), 76'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fma16_vector_recorder.md
Name: fma16_vector_recorder

Overview:
- Captures fma16 operations and their outcomes as packed 76-bit test-vector words in an on-chip buffer, then streams them out in order on a dump port.
- Word layout is {x, y, z, ctrl, result, flags}, the same layout the fma16 vector benches load, so captured traffic replays as a vector file.
- Sits beside fma16 on its operand/result interface; it is the vector writer paired with the bench-side vector reader.

Parameters:
- DEPTH, 1024, number of 76-bit entries in the buffer; must be a power of 2 and at least 2.
- AW, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- start  in  1  pulse; clears the buffer and begins recording
- dump  in  1  pulse; begins streaming the buffer contents
- in_valid  in  1  capture request
- in_ready  out  1  recorder can accept a capture
- x, y, z  in  16 each  fma16 operands
- roundmode  in  2  rounding mode
- mul, add, negp, negz  in  1 each  fma16 op controls
- result  in  16  fma16 result
- flags  in  4  fma16 flags
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  76  packed vector word
- out_last  out  1  out_data is the final stored entry
- count  out  AW+1  number of valid entries
- full  out  1  count == DEPTH
- state  out  2  0=IDLE, 1=REC, 2=DUMP

Behaviour:
- Reset (reset==0 at a posedge):
  - state=IDLE; count=0; write and read pointers=0; out_valid=0; out_last=0; out_data=0.
  - Reset overrides any operation in progress, including mid-dump; buffer contents become don't-care.
- Packing:
  - ctrl = {2'b00, roundmode, mul, add, negp, negz}.
  - word = {x, y, z, ctrl, result, flags}; bits [75:60]=x, [59:44]=y, [43:28]=z, [27:20]=ctrl, [19:4]=result, [3:0]=flags.
- IDLE:
  - in_ready=0.
  - start -> REC with count:=0, wptr:=0.
  - dump with count>0 -> DUMP with rptr:=0.
  - dump with count==0 is ignored.
  - start has priority over dump when both are asserted.
- REC:
  - in_ready = !full (registered-state decode only; no combinational path from inputs).
  - in_valid && in_ready at a posedge writes word to mem[wptr]; then wptr++ and count++.
  - When full, in_ready=0 and requests stall; no overwrite, no wrap.
  - dump -> DUMP. A handshake in the same cycle is still written and included in the dump.
  - start while in REC is ignored.
- DUMP:
  - in_ready=0.
  - Buffer read is synchronous with 1-cycle latency.
  - out_valid first asserts exactly 2 cycles after the dump edge.
  - Entries are delivered in write order, index 0 to count-1.
  - out_data/out_valid/out_last stay stable while out_valid && !out_ready.
  - With out_ready held high, throughput is 1 word per cycle with no bubbles (prefetch required).
  - out_last=1 only with entry count-1.
  - Handshake on the last word -> IDLE, out_valid=0 next cycle.
  - count is retained after a dump, so a repeat dump replays the same data.
  - start and dump are ignored while in DUMP.
- count saturates at DEPTH; full is combinational from count.

Test Plan:
- Reset then start; capture x=3C00 y=4000 z=0000 roundmode=01 mul=1 add=negp=negz=0 result=4000 flags=0; dump with out_ready=1 -> exactly one word 0x3C00_4000_0000_18_4000_0, out_last=1, count=1, state returns to 0.
- start, capture 3 vectors on consecutive cycles, dump with out_ready=1 -> out_valid at dump+2 cycles, 3 words on 3 consecutive cycles in order, out_last only on the 3rd.
- DEPTH=4: offer 6 captures -> 4 accepted, in_ready=0 and full=1 after the 4th; dump returns only the first 4.
- During a dump of 3 entries, toggle out_ready 1,0,0,1,1 -> data held stable across stalls, no duplicated or lost words, count still 3 afterwards; a second dump repeats identical output.
- dump in the same cycle as an accepted capture -> that entry is included as the last word. Assert dump with count=0 in IDLE -> state stays 0, out_valid stays 0.
- Drive reset=0 during the 2nd word of a dump -> next cycle state=0, out_valid=0, count=0; a subsequent dump is ignored.
